// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel and decode-side channel of the fetch stage.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [31:0]        imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc_plus4;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Redirect priority (jr > branch > jump) and target arithmetic, purely combinational.
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] redir_base,
    input  logic        redir_branch,
    input  logic [15:0] redir_imm,
    input  logic        redir_jump,
    input  logic [25:0] redir_index,
    input  logic        redir_jr,
    input  logic [31:0] redir_jr_addr,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] branch_off_s;

    assign branch_off_s = {{14{redir_imm[15]}}, redir_imm, 2'b00};
    assign redirect     = redir_jr | redir_branch | redir_jump;

    // Priority mux over the three redirect sources
    always_comb begin
        target = 32'd0;
        if (redir_jr) begin
            target = redir_jr_addr & 32'hFFFF_FFFC;
        end else if (redir_branch) begin
            target = redir_base + branch_off_s;
        end else if (redir_jump) begin
            target = {redir_base[31:28], redir_index, 2'b00};
        end else begin
            target = 32'd0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time and buffers one instruction for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    input  logic [31:0]  redir_base,
    input  logic         redir_branch,
    input  logic [15:0]  redir_imm,
    input  logic         redir_jump,
    input  logic [25:0]  redir_index,
    input  logic         redir_jr,
    input  logic [31:0]  redir_jr_addr
);

    fetch_state_e       state_r, state_n;
    logic [31:0]        pc_r, pc_n;
    logic [31:0]        fetch_pc_r, fetch_pc_n;
    logic               drop_r, drop_n;
    logic               load_s;
    logic [INSTR_W-1:0] instr_r;
    logic [31:0]        ipc_r, ipc_plus4_r;
    logic               redirect_s;
    logic [31:0]        target_s;

    npc_calc u_npc (
        .redir_base    (redir_base),
        .redir_branch  (redir_branch),
        .redir_imm     (redir_imm),
        .redir_jump    (redir_jump),
        .redir_index   (redir_index),
        .redir_jr      (redir_jr),
        .redir_jr_addr (redir_jr_addr),
        .redirect      (redirect_s),
        .target        (target_s)
    );

    // Next-state, next-PC and drop/buffer-load decisions
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        fetch_pc_n = fetch_pc_r;
        drop_n     = drop_r;
        load_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    fetch_pc_n = pc_r;
                    pc_n       = redirect_s ? target_s : (pc_r + PC_STEP);
                    drop_n     = redirect_s;
                    state_n    = S_WAIT;
                end else if (redirect_s) begin
                    pc_n = target_s;
                end else begin
                    pc_n = pc_r;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    drop_n = 1'b0;
                    // A stale or newly wrong-path response is discarded and fetch restarts
                    if (drop_r || redirect_s) begin
                        state_n = S_REQ;
                        pc_n    = redirect_s ? target_s : pc_r;
                    end else begin
                        load_s  = 1'b1;
                        state_n = S_HOLD;
                    end
                end else if (redirect_s) begin
                    pc_n   = target_s;
                    drop_n = 1'b1;
                end else begin
                    drop_n = drop_r;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    pc_n    = target_s;
                    state_n = S_REQ;
                end else if (bus.if_ready) begin
                    state_n = S_REQ;
                end else begin
                    state_n = S_HOLD;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control state and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            fetch_pc_r <= 32'd0;
            drop_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            fetch_pc_r <= fetch_pc_n;
            drop_r     <= drop_n;
        end
    end

    // Single-entry instruction buffer presented to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r     <= {INSTR_W{1'b0}};
            ipc_r       <= 32'd0;
            ipc_plus4_r <= 32'd0;
        end else if (load_s) begin
            instr_r     <= bus.imem_rsp_data;
            ipc_r       <= fetch_pc_r;
            ipc_plus4_r <= fetch_pc_r + PC_STEP;
        end else begin
            instr_r     <= instr_r;
            ipc_r       <= ipc_r;
            ipc_plus4_r <= ipc_plus4_r;
        end
    end

    assign bus.imem_req_valid = (state_r == S_REQ);
    assign bus.imem_addr      = pc_r;
    assign bus.if_valid       = (state_r == S_HOLD);
    assign bus.if_instr       = instr_r;
    assign bus.if_pc          = ipc_r;
    assign bus.if_pc_plus4    = ipc_plus4_r;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle datapath. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers one returned instruction. It presents that instruction, its PC and its PC+4 to decode over a valid/ready channel. Redirects from the branch/jump/jr resolution logic retarget the PC and squash any wrong-path instruction, whether it is buffered or still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  fetch byte address, bits [1:0] always 0
- imem_rsp_valid  in  1  response data valid (arrives ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- redir_base  in  32  PC+4 of the resolving instruction
- redir_branch  in  1  taken branch; target = redir_base + (sext(redir_imm) << 2)
- redir_imm  in  16  branch offset in words
- redir_jump  in  1  j/jal; target = {redir_base[31:28], redir_index, 2'b00}
- redir_index  in  26  jump instruction index
- redir_jr  in  1  jr; target = {redir_jr_addr[31:2], 2'b00}
- redir_jr_addr  in  32  register jump target
- if_valid  out  1  buffered instruction valid to decode
- if_ready  in  1  decode accepts
- if_instr  out  32  instruction
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4

## Operation
- Redirect priority: jr > branch > jump. Any of the three asserted = redirect. Target arithmetic is modulo 2^32.
- States:
  - S_IDLE: reset state. Goes unconditionally to S_REQ.
  - S_REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready: capture fetch_pc=pc, set pc=pc+4, go to S_WAIT.
  - S_WAIT: one request outstanding. On imem_rsp_valid:
    - drop=1: discard the response, clear drop, go to S_REQ.
    - drop=0: load buffer {if_instr=data, if_pc=fetch_pc, if_pc_plus4=fetch_pc+4}, go to S_HOLD.
  - S_HOLD: if_valid=1, buffer held stable. On if_ready: go to S_REQ.
- Redirect handling (the redirect target always wins over pc+4):
  - In S_REQ without acceptance: pc=target, stay in S_REQ.
  - In S_REQ with acceptance in the same cycle: pc=target, drop=1, go to S_WAIT.
  - In S_WAIT with no response: pc=target, drop=1.
  - In S_WAIT with a response in the same cycle: discard the response, pc=target, go to S_REQ.
  - In S_HOLD: invalidate the buffer (if_valid=0 next cycle), pc=target, go to S_REQ. If if_ready is also high that cycle, the transfer still completes; decode squashes it.
- At most one request is outstanding. No new request is issued while in S_WAIT or S_HOLD.

## Timing
- Reset values: state=S_IDLE, pc=RESET_PC, drop=0, if_valid=0, if_instr/if_pc/if_pc_plus4=0, imem_req_valid=0, imem_addr=RESET_PC.
- The first request is asserted in the second cycle after rst_n deasserts.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency with a 1-cycle memory: request accepted at cycle N, response at N+1, if_valid at N+2. Steady-state throughput is 1 instruction per 3 cycles.
- Redirect at cycle N: the request for the target is visible at N+1 (from S_REQ/S_HOLD), or one cycle after the dropped response arrives (from S_WAIT).
- Reset asserted mid-operation: all state clears immediately. A late response that arrives after reset release and before the first new request is ignored (state S_IDLE/S_REQ).

## Structure
- Shared package fetch_pkg: state enum {S_IDLE, S_REQ, S_WAIT, S_HOLD}, INSTR_W=32, PC_STEP=4.
- Sub-module npc_calc: combinational redirect priority mux and target arithmetic (sign extension, shift, region concatenation). Outputs redirect and target.

## Test plan
- Reset with RESET_PC=0x40, memory with 1-cycle latency and if_ready=1 -> requests to 0x40, 0x44, 0x48; if_pc/if_pc_plus4 = 0x40/0x44 etc.; one instruction every 3 cycles.
- if_ready held low for 5 cycles in S_HOLD -> if_instr/if_pc stable, no new imem request; fetch resumes one cycle after if_ready rises.
- redir_branch with base 0x100, imm 0xFFFE while in S_WAIT -> in-flight response dropped, next request to 0xF8, no wrong-path if_valid.
- redir_jump and redir_branch together, base 0xA000_0010, index 0x10 -> branch target wins; redir_jr also asserted with addr 0x1237 -> request to 0x1234.
- imem_req_ready low for 4 cycles -> imem_addr held constant, imem_req_valid stays high; redirect during the stall changes imem_addr next cycle.
- rst_n pulsed low while in S_HOLD -> if_valid=0 immediately, request to RESET_PC after release.
